// File: rtl/litedram_axi_pkg.sv
// Shared constants, state encodings and helpers for the LiteDRAM AXI guard.
package litedram_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        MODE_INIT = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_FAIL = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PASS = 2'd1,
        W_SINK = 2'd2,
        W_RESP = 2'd3
    } wstate_e;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_LOCAL = 1'b1
    } rstate_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/litedram_axi_otcnt.sv
// Outstanding-transaction counter, clamped to [0, MAX].
module litedram_axi_otcnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != CW'(MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // A retiring transaction frees its slot in the same cycle, so a new one may take it.
    assign full_o  = (cnt_q == CW'(MAX)) && !dec_i;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/litedram_axi_guard.sv
// AXI4 guard in front of the LiteDRAM user port: calibration gating,
// outstanding caps and local SLVERR/DECERR responses.
module litedram_axi_guard
    import litedram_axi_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int UP_AW      = 32,
    parameter int DRAM_AW    = 27,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_OUT    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_done,
    input  logic                    init_error,
    // upstream AW / W / B
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [UP_AW-1:0]        i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    // upstream AR / R
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [UP_AW-1:0]        i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    // downstream user port
    output logic [ID_WIDTH-1:0]     dram_aw_id,
    output logic [DRAM_AW-1:0]      dram_aw_addr,
    output logic [7:0]              dram_aw_len,
    output logic [2:0]              dram_aw_size,
    output logic [1:0]              dram_aw_burst,
    output logic                    dram_aw_valid,
    input  logic                    dram_aw_ready,
    output logic [DATA_WIDTH-1:0]   dram_w_data,
    output logic [DATA_WIDTH/8-1:0] dram_w_strb,
    output logic                    dram_w_last,
    output logic                    dram_w_valid,
    input  logic                    dram_w_ready,
    input  logic [ID_WIDTH-1:0]     dram_b_id,
    input  logic [1:0]              dram_b_resp,
    input  logic                    dram_b_valid,
    output logic                    dram_b_ready,
    output logic [ID_WIDTH-1:0]     dram_ar_id,
    output logic [DRAM_AW-1:0]      dram_ar_addr,
    output logic [7:0]              dram_ar_len,
    output logic [2:0]              dram_ar_size,
    output logic [1:0]              dram_ar_burst,
    output logic                    dram_ar_valid,
    input  logic                    dram_ar_ready,
    input  logic [ID_WIDTH-1:0]     dram_r_id,
    input  logic [DATA_WIDTH-1:0]   dram_r_data,
    input  logic [1:0]              dram_r_resp,
    input  logic                    dram_r_last,
    input  logic                    dram_r_valid,
    output logic                    dram_r_ready,
    // status and debug
    output logic [1:0]              o_mode,
    output logic [15:0]             o_err_cnt,
    output logic [1:0]              o_wstate,
    output logic                    o_rstate
);

    mode_e                mode_q, mode_d;
    wstate_e              wstate_q, wstate_d;
    rstate_e              rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]  bid_q, bid_d, rid_q, rid_d;
    logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
    logic [7:0]           rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [15:0]          err_cnt_q;
    logic                 running, failing, aw_local, ar_local;
    logic [1:0]           loc_resp;
    logic                 wr_inc, wr_dec, wr_full, wr_empty;
    logic                 rd_inc, rd_dec, rd_full, rd_empty;
    logic                 aw_loc_hs, ar_loc_hs;
    logic [1:0]           err_inc;

    // Calibration status is sticky: once failed, the guard never forwards again.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_INIT: if (init_error) mode_d = MODE_FAIL;
                       else if (init_done) mode_d = MODE_RUN;
            MODE_RUN:  if (init_error) mode_d = MODE_FAIL;
            default:   mode_d = mode_q;
        endcase
    end

    assign running  = (mode_q != MODE_INIT);
    assign failing  = (mode_q == MODE_FAIL);
    assign loc_resp = failing ? RESP_SLVERR : RESP_DECERR;
    assign aw_local = failing || (i_awaddr[UP_AW-1:DRAM_AW] != '0);
    assign ar_local = failing || (i_araddr[UP_AW-1:DRAM_AW] != '0);

    assign dram_aw_id    = i_awid;
    assign dram_aw_addr  = i_awaddr[DRAM_AW-1:0];
    assign dram_aw_len   = i_awlen;
    assign dram_aw_size  = i_awsize;
    assign dram_aw_burst = i_awburst;
    assign dram_w_data   = i_wdata;
    assign dram_w_strb   = i_wstrb;
    assign dram_w_last   = i_wlast;
    assign dram_ar_id    = i_arid;
    assign dram_ar_addr  = i_araddr[DRAM_AW-1:0];
    assign dram_ar_len   = i_arlen;
    assign dram_ar_size  = i_arsize;
    assign dram_ar_burst = i_arburst;

    always_comb begin
        wstate_d      = wstate_q;
        bid_d         = bid_q;
        bresp_d       = bresp_q;
        o_awready     = 1'b0;
        dram_aw_valid = 1'b0;
        o_wready      = 1'b0;
        dram_w_valid  = 1'b0;
        o_bvalid      = running && dram_b_valid;
        o_bid         = dram_b_id;
        o_bresp       = dram_b_resp;
        dram_b_ready  = running && i_bready;
        wr_inc        = 1'b0;
        aw_loc_hs     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (running && aw_local) begin
                    // Local answers only once the forwarded writes have drained,
                    // so B ordering toward the master is preserved.
                    o_awready = wr_empty;
                    if (i_awvalid && wr_empty) begin
                        aw_loc_hs = 1'b1;
                        bid_d     = i_awid;
                        bresp_d   = loc_resp;
                        wstate_d  = W_SINK;
                    end
                end else if (running) begin
                    dram_aw_valid = i_awvalid && !wr_full;
                    o_awready     = dram_aw_ready && !wr_full;
                    if (i_awvalid && dram_aw_ready && !wr_full) begin
                        wr_inc   = 1'b1;
                        wstate_d = W_PASS;
                    end
                end
            end
            W_PASS: begin
                dram_w_valid = i_wvalid;
                o_wready     = dram_w_ready;
                if (i_wvalid && dram_w_ready && i_wlast) wstate_d = W_IDLE;
            end
            W_SINK: begin
                o_wready = 1'b1;
                if (i_wvalid && i_wlast) wstate_d = W_RESP;
            end
            W_RESP: begin
                o_bvalid     = 1'b1;
                o_bid        = bid_q;
                o_bresp      = bresp_q;
                dram_b_ready = 1'b0;
                if (i_bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d      = rstate_q;
        rid_d         = rid_q;
        rresp_d       = rresp_q;
        rlen_d        = rlen_q;
        rbeat_d       = rbeat_q;
        o_arready     = 1'b0;
        dram_ar_valid = 1'b0;
        o_rvalid      = running && dram_r_valid;
        o_rid         = dram_r_id;
        o_rdata       = dram_r_data;
        o_rresp       = dram_r_resp;
        o_rlast       = dram_r_last;
        dram_r_ready  = running && i_rready;
        rd_inc        = 1'b0;
        ar_loc_hs     = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (running && ar_local) begin
                    o_arready = rd_empty;
                    if (i_arvalid && rd_empty) begin
                        ar_loc_hs = 1'b1;
                        rid_d     = i_arid;
                        rresp_d   = loc_resp;
                        rlen_d    = i_arlen;
                        rbeat_d   = '0;
                        rstate_d  = R_LOCAL;
                    end
                end else if (running) begin
                    dram_ar_valid = i_arvalid && !rd_full;
                    o_arready     = dram_ar_ready && !rd_full;
                    rd_inc        = i_arvalid && dram_ar_ready && !rd_full;
                end
            end
            R_LOCAL: begin
                o_rvalid     = 1'b1;
                o_rid        = rid_q;
                o_rdata      = '0;
                o_rresp      = rresp_q;
                o_rlast      = (rbeat_q == rlen_q);
                dram_r_ready = 1'b0;
                if (i_rready) begin
                    if (rbeat_q == rlen_q) rstate_d = R_IDLE;
                    else                   rbeat_d  = rbeat_q + 8'd1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign wr_dec  = dram_b_valid && dram_b_ready;
    assign rd_dec  = dram_r_valid && dram_r_ready && dram_r_last;
    assign err_inc = {1'b0, aw_loc_hs} + {1'b0, ar_loc_hs};

    litedram_axi_otcnt #(.MAX(MAX_OUT)) u_wr_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(wr_inc), .dec_i(wr_dec),
        .full_o(wr_full), .empty_o(wr_empty)
    );

    litedram_axi_otcnt #(.MAX(MAX_OUT)) u_rd_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(rd_inc), .dec_i(rd_dec),
        .full_o(rd_full), .empty_o(rd_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_INIT;
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            mode_q   <= mode_d;
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            rid_q    <= rid_d;
            rresp_q  <= rresp_d;
            rlen_q   <= rlen_d;
            rbeat_q  <= rbeat_d;
            if (err_inc != 2'd0) err_cnt_q <= sat_add16(err_cnt_q, err_inc);
        end
    end

    assign o_mode    = mode_q;
    assign o_err_cnt = err_cnt_q;
    assign o_wstate  = wstate_q;
    assign o_rstate  = rstate_q;

endmodule
